// File: rtl/life_scan_port.sv
// life_scan_port: serial scan-chain driver for the 16-cell life array.
//
// Accepts a parallel pattern over a valid/ready handshake. It shifts the
// pattern into the array one bit per strobe and captures the bits leaving
// the chain, then presents them as a parallel dump word. In recirc mode each
// bit read is written straight back, so the array contents are preserved.
// While a transfer is in flight run_inhibit holds off the generation step.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   load_valid/ready    transfer request handshake (ready only in IDLE)
//   load_data, recirc   pattern and mode, both sampled at accept
//   dump_valid/data     one-cycle pulse with the captured array contents
//   run_inhibit         high whenever a transfer is in progress
//   scan, scan_write_enb, scan_write_val   strobe and write bit to the array
//   scan_read_val       bit leaving the chain, valid before the strobe edge
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for load_valid; load_ready high
// SHIFT | strobe cycle: one bit written, one bit captured
// GAP   | SHIFT_GAP quiet cycles between consecutive strobes
// DONE  | dump_valid pulse; dump_data holds the captured word

module life_scan_port #(
  parameter int CELLS     = 16,
  parameter int SHIFT_GAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [CELLS-1:0] load_data,
  input  logic             recirc,
  output logic             dump_valid,
  output logic [CELLS-1:0] dump_data,
  output logic             run_inhibit,
  output logic             scan,
  output logic             scan_write_enb,
  output logic             scan_write_val,
  input  logic             scan_read_val
);

  localparam int CNT_W = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CELLS - 1);
  // Gap counter counts down to zero, so it is loaded with one less than the gap.
  localparam logic [2:0] GAP_LOAD = (SHIFT_GAP > 0) ? 3'(SHIFT_GAP - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state;
  logic [CELLS-1:0] shift_q;
  logic [CELLS-1:0] capture_q;
  logic             recirc_q;
  logic             strobe_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       gap_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      strobe_q   <= 1'b0;
      shift_q    <= '0;
      capture_q  <= '0;
      recirc_q   <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shift_q    <= load_data;
            recirc_q   <= recirc;
            capture_q  <= '0;
            bit_cnt    <= '0;
            load_ready <= 1'b0;
            strobe_q   <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          capture_q <= {capture_q[CELLS-2:0], scan_read_val};
          shift_q   <= shift_q << 1;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            // Last strobe: the final captured bit goes straight into the dump word.
            strobe_q   <= 1'b0;
            dump_valid <= 1'b1;
            dump_data  <= {capture_q[CELLS-2:0], scan_read_val};
            state      <= DONE;
          end else if (SHIFT_GAP == 0) begin
            strobe_q <= 1'b1;
            state    <= SHIFT;
          end else begin
            strobe_q <= 1'b0;
            gap_cnt  <= GAP_LOAD;
            state    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 3'd0) begin
            strobe_q <= 1'b1;
            state    <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE: begin
          dump_valid <= 1'b0;
          load_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          strobe_q   <= 1'b0;
          dump_valid <= 1'b0;
          load_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign scan           = strobe_q;
  assign scan_write_enb = strobe_q;
  // Recirc writes back the bit being read, so the write value follows the chain output.
  assign scan_write_val = strobe_q & (recirc_q ? scan_read_val : shift_q[CELLS-1]);
  assign run_inhibit    = (state != IDLE);

endmodule

// File: tb/tb_life_scan_port.sv
module tb_life_scan_port;
  localparam int CELLS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        recirc = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] load_data = '0;

  logic        lr1, dv1, ri1, sc1, we1, wv1;
  logic [15:0] dd1;
  logic        lr0, dv0, ri0, sc0, we0, wv0;
  logic [15:0] dd0;
  logic        srv;

  // Behavioural 16-cell array: shifts toward the MSB on each strobe.
  logic [15:0] arr;
  logic [15:0] arr_val = '0;
  logic        arr_load = 1'b0;

  logic        cur_scan, cur_we, cur_wv, cur_dv, cur_lr, cur_ri;
  logic [15:0] cur_dd;
  assign cur_scan = sel ? sc0 : sc1;
  assign cur_we   = sel ? we0 : we1;
  assign cur_wv   = sel ? wv0 : wv1;
  assign cur_dv   = sel ? dv0 : dv1;
  assign cur_lr   = sel ? lr0 : lr1;
  assign cur_ri   = sel ? ri0 : ri1;
  assign cur_dd   = sel ? dd0 : dd1;
  assign srv      = arr[15];

  always @(posedge clk) begin
    if (arr_load) arr <= arr_val;
    else if (cur_scan) arr <= {arr[14:0], cur_wv};
  end

  life_scan_port #(.CELLS(CELLS), .SHIFT_GAP(1)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid & ~sel), .load_ready(lr1),
    .load_data(load_data), .recirc(recirc), .dump_valid(dv1), .dump_data(dd1),
    .run_inhibit(ri1), .scan(sc1), .scan_write_enb(we1), .scan_write_val(wv1),
    .scan_read_val(srv));

  life_scan_port #(.CELLS(CELLS), .SHIFT_GAP(0)) dut_g0 (
    .clk(clk), .reset(reset), .load_valid(load_valid & sel), .load_ready(lr0),
    .load_data(load_data), .recirc(recirc), .dump_valid(dv0), .dump_data(dd0),
    .run_inhibit(ri0), .scan(sc0), .scan_write_enb(we0), .scan_write_val(wv0),
    .scan_read_val(srv));

  int tests_run = 0;
  int tests_failed = 0;

  // Observations collected by xfer
  int          n_strobe, n_dv, dump_cyc;
  int          strobe_cyc[$];
  logic        wq[$];
  logic        rq[$];
  logic        we_ok;
  logic [15:0] dump_val;
  logic        pre_lr, ri_first, ri_after, lr_after, lr_done, lr_at_busy;
  logic        rst_seen, rst_scan, rst_ri, rst_lr;
  logic [15:0] rst_dd;

  task automatic preload(input logic [15:0] v);
    @(negedge clk);
    arr_val = v;
    arr_load = 1'b1;
    @(negedge clk);
    arr_load = 1'b0;
  endtask

  // Starts one transfer on the selected instance and watches it for 'budget' cycles.
  task automatic xfer(input logic [15:0] data, input logic rc, input int busy_at,
                      input int rst_at, input int budget);
    logic pulse_on;
    pulse_on = 1'b0;
    @(negedge clk);
    pre_lr = cur_lr;
    load_data = data;
    recirc = rc;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data = 16'($urandom);
    recirc = ~rc;
    n_strobe = 0; n_dv = 0; dump_cyc = -1; dump_val = 'x;
    strobe_cyc.delete(); wq.delete(); rq.delete();
    we_ok = 1'b1; ri_first = 1'bx; ri_after = 1'bx; lr_after = 1'bx; lr_done = 1'bx;
    lr_at_busy = 1'bx; rst_seen = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (pulse_on) begin
        load_valid = 1'b0;
        pulse_on = 1'b0;
      end
      if (reset) begin
        reset = 1'b0;
        rst_seen = 1'b1;
        rst_scan = cur_scan; rst_ri = cur_ri; rst_lr = cur_lr; rst_dd = cur_dd;
      end
      if (cur_we !== cur_scan) we_ok = 1'b0;
      if (cur_scan === 1'b1) begin
        n_strobe++;
        strobe_cyc.push_back(c);
        wq.push_back(cur_wv);
        rq.push_back(srv);
      end
      if (cur_dv === 1'b1) begin
        n_dv++;
        dump_cyc = c;
        dump_val = cur_dd;
        lr_done = cur_lr;
      end
      if (c == 1) ri_first = cur_ri;
      if (dump_cyc > 0 && c == dump_cyc + 1) begin
        ri_after = cur_ri;
        lr_after = cur_lr;
      end
      if (cur_scan === 1'b1 && n_strobe == busy_at) begin
        lr_at_busy = cur_lr;
        load_data = 16'hFFFF;
        recirc = 1'b0;
        load_valid = 1'b1;
        pulse_on = 1'b1;
      end
      if (cur_scan === 1'b1 && n_strobe == rst_at) reset = 1'b1;
    end
  endtask

  task automatic test_reset;
    sel = 1'b0;
    reset = 1'b1;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if ({lr1, sc1, we1, wv1, dv1, ri1} !== 6'b100000) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: {lr,scan,we,wv,dv,ri} got %b exp 100000", c, {lr1, sc1, we1, wv1, dv1, ri1});
      end
    end
    tests_run++;
    if (dd1 !== 16'h0000) begin tests_failed++; $display("FAIL reset_dump_data: got %h exp 0000", dd1); end
    tests_run++;
    if ({lr0, sc0, dv0, ri0} !== 4'b1000) begin tests_failed++; $display("FAIL reset_g0: got %b exp 1000", {lr0, sc0, dv0, ri0}); end
  endtask

  task automatic test_load;
    sel = 1'b0;
    preload(16'h0000);
    xfer(16'hA5C3, 1'b0, -1, -1, 40);
    tests_run++;
    if (pre_lr !== 1'b1) begin tests_failed++; $display("FAIL load_ready_idle: got %b exp 1", pre_lr); end
    tests_run++;
    if (n_strobe !== 16) begin tests_failed++; $display("FAIL load_strobes: got %0d exp 16", n_strobe); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (strobe_cyc.size() <= i || strobe_cyc[i] !== 1 + 2 * i) begin
        tests_failed++;
        $display("FAIL load_strobe_time %0d: got %0d exp %0d", i, (strobe_cyc.size() > i) ? strobe_cyc[i] : -1, 1 + 2 * i);
      end
    end
    tests_run++;
    if (we_ok !== 1'b1) begin tests_failed++; $display("FAIL load_we_eq_scan: got %b exp 1", we_ok); end
    tests_run++;
    if (dump_cyc !== 32) begin tests_failed++; $display("FAIL load_latency: got %0d exp 32", dump_cyc); end
    tests_run++;
    if (dump_val !== 16'h0000) begin tests_failed++; $display("FAIL load_dump: got %h exp 0000", dump_val); end
    tests_run++;
    if (arr !== 16'hA5C3) begin tests_failed++; $display("FAIL load_array: got %h exp a5c3", arr); end
    tests_run++;
    if (ri_first !== 1'b1) begin tests_failed++; $display("FAIL load_inhibit_rise: got %b exp 1", ri_first); end
    tests_run++;
    if ({ri_after, lr_after} !== 2'b01) begin tests_failed++; $display("FAIL load_inhibit_fall: {ri,lr} got %b exp 01", {ri_after, lr_after}); end
    tests_run++;
    if (lr_done !== 1'b0) begin tests_failed++; $display("FAIL load_ready_in_done: got %b exp 0", lr_done); end
    tests_run++;
    if (n_dv !== 1) begin tests_failed++; $display("FAIL load_dv_count: got %0d exp 1", n_dv); end
  endtask

  task automatic test_recirc;
    logic [15:0] prior;
    sel = 1'b0;
    prior = arr;
    xfer(16'($urandom), 1'b1, -1, -1, 40);
    tests_run++;
    if (dump_val !== 16'hA5C3) begin tests_failed++; $display("FAIL recirc_dump: got %h exp a5c3", dump_val); end
    tests_run++;
    if (arr !== prior) begin tests_failed++; $display("FAIL recirc_array: got %h exp %h", arr, prior); end
    tests_run++;
    if (n_strobe !== 16) begin tests_failed++; $display("FAIL recirc_strobes: got %0d exp 16", n_strobe); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (wq.size() <= i || rq.size() <= i || wq[i] !== rq[i] || rq[i] !== prior[15 - i]) begin
        tests_failed++;
        $display("FAIL recirc_bit %0d: write %b read %b exp %b", i,
                 (wq.size() > i) ? wq[i] : 1'bx, (rq.size() > i) ? rq[i] : 1'bx, prior[15 - i]);
      end
    end
  endtask

  task automatic test_busy_load;
    logic [15:0] v;
    sel = 1'b0;
    v = 16'($urandom);
    xfer(v, 1'b0, 5, -1, 40);
    tests_run++;
    if (lr_at_busy !== 1'b0) begin tests_failed++; $display("FAIL busy_ready: got %b exp 0", lr_at_busy); end
    tests_run++;
    if (n_strobe !== 16) begin tests_failed++; $display("FAIL busy_strobes: got %0d exp 16", n_strobe); end
    tests_run++;
    if (arr !== v) begin tests_failed++; $display("FAIL busy_array: got %h exp %h", arr, v); end
    tests_run++;
    if (dump_val !== 16'hA5C3) begin tests_failed++; $display("FAIL busy_dump: got %h exp a5c3", dump_val); end
    tests_run++;
    if (n_dv !== 1) begin tests_failed++; $display("FAIL busy_dv_count: got %0d exp 1", n_dv); end
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    xfer(16'($urandom), 1'b0, -1, 9, 40);
    tests_run++;
    if (rst_seen !== 1'b1) begin tests_failed++; $display("FAIL rstmid_applied: got %b exp 1", rst_seen); end
    tests_run++;
    if ({rst_scan, rst_ri, rst_lr} !== 3'b001) begin tests_failed++; $display("FAIL rstmid_state: {scan,ri,lr} got %b exp 001", {rst_scan, rst_ri, rst_lr}); end
    tests_run++;
    if (rst_dd !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_dump_data: got %h exp 0000", rst_dd); end
    tests_run++;
    if (n_dv !== 0) begin tests_failed++; $display("FAIL rstmid_no_dump: got %0d exp 0", n_dv); end
    tests_run++;
    if (n_strobe !== 9) begin tests_failed++; $display("FAIL rstmid_strobes: got %0d exp 9", n_strobe); end
  endtask

  task automatic test_gap0;
    logic [15:0] prior;
    sel = 1'b1;
    prior = 16'($urandom);
    preload(prior);
    xfer(16'h8001, 1'b0, -1, -1, 24);
    tests_run++;
    if (n_strobe !== 16) begin tests_failed++; $display("FAIL gap0_strobes: got %0d exp 16", n_strobe); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (strobe_cyc.size() <= i || strobe_cyc[i] !== 1 + i) begin
        tests_failed++;
        $display("FAIL gap0_strobe_time %0d: got %0d exp %0d", i, (strobe_cyc.size() > i) ? strobe_cyc[i] : -1, 1 + i);
      end
    end
    tests_run++;
    if (dump_cyc !== 17) begin tests_failed++; $display("FAIL gap0_latency: got %0d exp 17", dump_cyc); end
    tests_run++;
    if (dump_val !== prior) begin tests_failed++; $display("FAIL gap0_dump: got %h exp %h", dump_val, prior); end
    tests_run++;
    if (arr !== 16'h8001) begin tests_failed++; $display("FAIL gap0_array: got %h exp 8001", arr); end
  endtask

  task automatic test_random;
    logic [15:0] prior, data, exp_arr;
    logic        rc;
    int          gap, lat;
    for (int n = 0; n < 8; n++) begin
      sel = n[0];
      gap = sel ? 0 : 1;
      lat = 2 + (CELLS - 1) * (1 + gap);
      if (n == 0 || n == 5) preload(16'($urandom));
      prior = arr;
      data = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      exp_arr = rc ? prior : data;
      xfer(data, rc, -1, -1, lat + 3);
      tests_run++;
      if (dump_val !== prior || dump_cyc !== lat) begin
        tests_failed++;
        $display("FAIL rand_dump %0d: got %h at %0d exp %h at %0d", n, dump_val, dump_cyc, prior, lat);
      end
      tests_run++;
      if (arr !== exp_arr || n_strobe !== 16) begin
        tests_failed++;
        $display("FAIL rand_array %0d: got %h/%0d strobes exp %h/16", n, arr, n_strobe, exp_arr);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] p, x, y;
    int          dv_cyc[$];
    logic [15:0] dv_dat[$];
    int          st_cyc[$];
    int          first_dv;
    logic        lr_at_done;
    sel = 1'b0;
    p = 16'($urandom);
    x = 16'($urandom);
    y = 16'($urandom);
    preload(p);
    first_dv = -10;
    lr_at_done = 1'bx;
    @(negedge clk);
    load_data = x;
    recirc = 1'b0;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_data = y;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (cur_scan === 1'b1) st_cyc.push_back(c);
      if (cur_dv === 1'b1) begin
        dv_cyc.push_back(c);
        dv_dat.push_back(cur_dd);
        if (first_dv < 0) begin
          first_dv = c;
          lr_at_done = cur_lr;
        end
      end
      if (c == first_dv + 2) load_valid = 1'b0;
    end
    load_valid = 1'b0;
    tests_run++;
    if (lr_at_done !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_in_done: got %b exp 0", lr_at_done); end
    tests_run++;
    if (dv_cyc.size() != 2 || dv_cyc[0] !== 32 || dv_cyc[1] !== 65) begin
      tests_failed++;
      $display("FAIL b2b_dump_times: got %0d pulses first %0d exp 2 pulses at 32,65", dv_cyc.size(),
               (dv_cyc.size() > 0) ? dv_cyc[0] : -1);
    end
    tests_run++;
    if (dv_dat.size() != 2 || dv_dat[0] !== p || dv_dat[1] !== x) begin
      tests_failed++;
      $display("FAIL b2b_dump_data: got %h exp %h then %h", (dv_dat.size() > 0) ? dv_dat[0] : 16'hxxxx, p, x);
    end
    tests_run++;
    if (st_cyc.size() != 32 || st_cyc[16] !== 34) begin
      tests_failed++;
      $display("FAIL b2b_strobes: got %0d strobes exp 32 with second run starting at 34", st_cyc.size());
    end
    tests_run++;
    if (arr !== y) begin tests_failed++; $display("FAIL b2b_array: got %h exp %h", arr, y); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_recirc();
    test_busy_load();
    test_reset_mid();
    test_gap0();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
